// File: rtl/winograd_tile_engine.sv
// winograd_tile_engine: one F(4x4,3x3) Winograd tile per start/done handshake.
// The datapath is time-multiplexed: a row-serial transform unit computes the
// kernel transform (KT), input transform (IT) and output transform (OT) one
// row per cycle, and MUL_LANES multipliers form the element-wise product (EW).
// The transforms are integer-scaled, so result_out is 576x the true
// convolution. All arithmetic wraps modulo 2^32.
//
// Optional feature macro: WINOGRAD_TILE_KCACHE_EN
//   When defined, the last captured kernel and its U are reused. A start whose
//   kernel matches the stored one skips KT. result_out is unaffected.
module winograd_tile_engine #(
  parameter int MUL_LANES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [31:0] kernel_in  [3][3],
  input  logic signed [31:0] tile_in    [6][6],
  output logic signed [31:0] result_out [4][4],
  output logic               done
);

  localparam int DATA_W = 32;
  localparam int EW_CYC = 36 / MUL_LANES;
  localparam bit LANES_OK = (MUL_LANES == 1)  || (MUL_LANES == 2)  ||
                            (MUL_LANES == 3)  || (MUL_LANES == 4)  ||
                            (MUL_LANES == 6)  || (MUL_LANES == 9)  ||
                            (MUL_LANES == 12) || (MUL_LANES == 18) ||
                            (MUL_LANES == 36);

  if (!LANES_OK) begin : g_bad_lanes
    $error("winograd_tile_engine: MUL_LANES must divide 36 (1,2,3,4,6,9,12,18,36)");
  end

  typedef logic signed [DATA_W-1:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KT,
    S_IT,
    S_EW,
    S_OT,
    S_DONE
  } state_t;

  // Gs = 24*G, B^T and A^T; all entries are small integers.
  localparam int GS [6][3] = '{
    '{ 6,  0,  0},
    '{-4, -4, -4},
    '{-4,  4, -4},
    '{ 1,  2,  4},
    '{ 1, -2,  4},
    '{ 0,  0, 24}
  };
  localparam int BT [6][6] = '{
    '{4,  0, -5,  0, 1, 0},
    '{0, -4, -4,  1, 1, 0},
    '{0,  4, -4, -1, 1, 0},
    '{0, -2, -1,  2, 1, 0},
    '{0,  2, -1, -2, 1, 0},
    '{0,  4,  0, -5, 0, 1}
  };
  localparam int AT [4][6] = '{
    '{1, 1,  1, 1,  1, 0},
    '{0, 1, -1, 2, -2, 0},
    '{0, 1,  1, 4,  4, 0},
    '{0, 1, -1, 8, -8, 1}
  };

  state_t     state;
  logic [5:0] cnt;
  logic [2:0] row_sel;

  word_t g_r [3][3];
  word_t d_r [6][6];
  word_t u_r [6][6];
  word_t v_r [6][6];
  word_t m_r [6][6];
  word_t y_r [3][4];

  word_t kt_t   [3];
  word_t kt_row [6];
  word_t it_t   [6];
  word_t it_row [6];
  word_t ot_t   [6];
  word_t ot_row [4];

  logic [2:0] ew_row [MUL_LANES];
  logic [2:0] ew_col [MUL_LANES];

  assign row_sel = cnt[2:0];

`ifdef WINOGRAD_TILE_KCACHE_EN
  logic kc_vld;
  logic kc_hit;

  // Cache hit when the stored kernel is valid and bit-equal to kernel_in.
  always_comb begin
    kc_hit = kc_vld;
    for (int a = 0; a < 3; a++) begin
      for (int b = 0; b < 3; b++) begin
        if (kernel_in[a][b] != g_r[a][b]) kc_hit = 1'b0;
      end
    end
  end
`endif

  // Kernel transform row: U[r][*] = (Gs[r] * g) * Gs^T.
  always_comb begin
    for (int l = 0; l < 3; l++) begin
      kt_t[l] = GS[row_sel][0] * g_r[0][l] +
                GS[row_sel][1] * g_r[1][l] +
                GS[row_sel][2] * g_r[2][l];
    end
    for (int j = 0; j < 6; j++) begin
      kt_row[j] = kt_t[0] * GS[j][0] + kt_t[1] * GS[j][1] + kt_t[2] * GS[j][2];
    end
  end

  // Input transform row: V[r][*] = (B^T[r] * d) * B.
  always_comb begin
    for (int c = 0; c < 6; c++) begin
      it_t[c] = BT[row_sel][0] * d_r[0][c] + BT[row_sel][1] * d_r[1][c] +
                BT[row_sel][2] * d_r[2][c] + BT[row_sel][3] * d_r[3][c] +
                BT[row_sel][4] * d_r[4][c] + BT[row_sel][5] * d_r[5][c];
    end
    for (int j = 0; j < 6; j++) begin
      it_row[j] = it_t[0] * BT[j][0] + it_t[1] * BT[j][1] + it_t[2] * BT[j][2] +
                  it_t[3] * BT[j][3] + it_t[4] * BT[j][4] + it_t[5] * BT[j][5];
    end
  end

  // Output transform row: Y[r][*] = (A^T[r] * M) * A.
  always_comb begin
    for (int c = 0; c < 6; c++) begin
      ot_t[c] = AT[row_sel][0] * m_r[0][c] + AT[row_sel][1] * m_r[1][c] +
                AT[row_sel][2] * m_r[2][c] + AT[row_sel][3] * m_r[3][c] +
                AT[row_sel][4] * m_r[4][c] + AT[row_sel][5] * m_r[5][c];
    end
    for (int j = 0; j < 4; j++) begin
      ot_row[j] = ot_t[0] * AT[j][0] + ot_t[1] * AT[j][1] + ot_t[2] * AT[j][2] +
                  ot_t[3] * AT[j][3] + ot_t[4] * AT[j][4] + ot_t[5] * AT[j][5];
    end
  end

  // Element-wise lane addressing: lane l handles flat index cnt*MUL_LANES+l.
  always_comb begin
    for (int l = 0; l < MUL_LANES; l++) begin
      ew_row[l] = 3'((int'(cnt) * MUL_LANES + l) / 6);
      ew_col[l] = 3'((int'(cnt) * MUL_LANES + l) % 6);
    end
  end

  // Sequencer and datapath registers; only the final OT edge touches result_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      done       <= 1'b0;
      result_out <= '{default: '0};
      g_r        <= '{default: '0};
      d_r        <= '{default: '0};
      u_r        <= '{default: '0};
      v_r        <= '{default: '0};
      m_r        <= '{default: '0};
      y_r        <= '{default: '0};
`ifdef WINOGRAD_TILE_KCACHE_EN
      kc_vld     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            g_r  <= kernel_in;
            d_r  <= tile_in;
            done <= 1'b0;
            cnt  <= '0;
`ifdef WINOGRAD_TILE_KCACHE_EN
            if (kc_hit) begin
              state <= S_IT;
            end else begin
              state  <= S_KT;
              kc_vld <= 1'b0;
            end
`else
            state <= S_KT;
`endif
          end
        end

        // ---- stage KT: one row of U per cycle
        S_KT: begin
          u_r[row_sel] <= kt_row;
          if (cnt == 6'd5) begin
            cnt   <= '0;
            state <= S_IT;
`ifdef WINOGRAD_TILE_KCACHE_EN
            kc_vld <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 6'd1;
          end
        end

        // ---- stage IT: one row of V per cycle
        S_IT: begin
          v_r[row_sel] <= it_row;
          if (cnt == 6'd5) begin
            cnt   <= '0;
            state <= S_EW;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end

        // ---- stage EW: MUL_LANES products per cycle, row-major
        S_EW: begin
          for (int l = 0; l < MUL_LANES; l++) begin
            m_r[ew_row[l]][ew_col[l]] <= u_r[ew_row[l]][ew_col[l]] *
                                         v_r[ew_row[l]][ew_col[l]];
          end
          if (cnt == 6'(EW_CYC - 1)) begin
            cnt   <= '0;
            state <= S_OT;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end

        // ---- stage OT: one row of Y per cycle; last row publishes the tile
        S_OT: begin
          if (cnt == 6'd3) begin
            for (int r = 0; r < 3; r++) begin
              result_out[r] <= y_r[r];
            end
            result_out[3] <= ot_row;
            done          <= 1'b1;
            cnt           <= '0;
            state         <= S_DONE;
          end else begin
            y_r[row_sel] <= ot_row;
            cnt          <= cnt + 6'd1;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
